// File: rtl/alu16_issue_seq.sv
// Command-issue / result-capture stage around a combinational 16-bit ALU.
// Optional accumulator operand source enabled by defining ALU_ACC_EN.
module alu16_issue_seq #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [15:0]              cmd_a,
    input  logic [15:0]              cmd_b,
    input  logic [3:0]               cmd_op,
    input  logic                     cmd_acc,
    output logic [15:0]              alu_a,
    output logic [15:0]              alu_b,
    output logic [3:0]               alu_s,
    input  logic [15:0]              alu_y,
    input  logic                     alu_carry,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_y,
    output logic                     res_carry,
    output logic                     res_zero,
    output logic                     res_neg,
    output logic                     res_dz,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [3:0]  OP_DIV = 4'b1011;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic        acc;
    } cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    cmd_t          mem [DEPTH];
    cmd_t          entry;
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    state_t        state;
    state_t        state_nxt;
    logic          push;
    logic          pop;
    logic          capture;
    logic          dz_pend;
    logic [15:0]   a_sel;

    assign cmd_ready  = (level < LW'(DEPTH));
    assign fifo_level = level;
    assign push       = cmd_valid & cmd_ready;
    assign entry      = '{a: cmd_a, b: cmd_b, op: cmd_op, acc: cmd_acc};
    assign head       = mem[rd_ptr];

    // Pop only when the result slot is guaranteed free at the capture edge
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if ((level != '0) && (!res_valid || res_ready)) begin
                    pop       = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                capture   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

`ifdef ALU_ACC_EN
    logic [15:0] acc;

    // Accumulator tracks the most recent captured result
    always_ff @(posedge clk) begin
        if (rst)          acc <= '0;
        else if (capture) acc <= alu_y;
    end

    assign a_sel = head.acc ? acc : head.a;
`else
    logic unused_acc;
    assign unused_acc = head.acc;
    assign a_sel      = head.a;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Operand registers hold across IDLE so the ALU inputs stay quiet
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_s   <= '0;
            dz_pend <= 1'b0;
        end else if (pop) begin
            alu_a   <= a_sel;
            alu_b   <= head.b;
            alu_s   <= head.op;
            dz_pend <= (head.op == OP_DIV) && (head.b == '0);
        end
    end

    // Capture takes priority over the consumer's take on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_y     <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_neg   <= 1'b0;
            res_dz    <= 1'b0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_y     <= alu_y;
            res_carry <= alu_carry;
            res_zero  <= (alu_y == '0);
            res_neg   <= alu_y[15];
            res_dz    <= dz_pend;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu16_issue_seq.sv
// Directed self-checking bench for alu16_issue_seq with a behavioural ALU attached.
module tb_alu16_issue_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_op;
    logic        cmd_acc;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_s;
    logic [15:0] alu_y;
    logic        alu_carry;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_y;
    logic        res_carry;
    logic        res_zero;
    logic        res_neg;
    logic        res_dz;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    alu16_issue_seq #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_acc(cmd_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_y(alu_y), .alu_carry(alu_carry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_carry(res_carry), .res_zero(res_zero),
        .res_neg(res_neg), .res_dz(res_dz),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the ALU: 0000 add, 0001 sub, 1011 divide, else AND
    always_comb begin
        logic [16:0] sum;
        sum       = '0;
        alu_y     = '0;
        alu_carry = 1'b0;
        case (alu_s)
            4'b0000: begin
                sum       = 17'(alu_a) + 17'(alu_b);
                alu_y     = sum[15:0];
                alu_carry = sum[16];
            end
            4'b0001: begin
                sum       = 17'(alu_a) + 17'(~alu_b) + 17'd1;
                alu_y     = sum[15:0];
                alu_carry = sum[16];
            end
            4'b1011: alu_y = (alu_b == '0) ? 16'h0000 : alu_a / alu_b;
            default: alu_y = alu_a & alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input logic acc);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_acc   = acc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (res_valid) break;
            tick();
        end
        check(tag, 32'(res_valid), 32'd1);
    endtask

    logic [15:0] exp_y [6];
    int          accepted;
    int          n;
    int          first_cyc;
    int          last_cyc;
    logic        stable;
    logic        seen;
    logic [15:0] held_y;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        cmd_acc   = 1'b0;
        res_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_level",     32'(fifo_level), 32'd0);
        check("rst_alu",       {alu_a, alu_b[11:0], alu_s}, 32'd0);

        // Single op: accept, pop, capture on consecutive edges
        res_ready = 1'b1;
        issue(16'hFFFF, 16'h0001, 4'b0000, 1'b0);
        check("lat_e0_valid", 32'(res_valid), 32'd0);
        tick();
        check("lat_e1_valid", 32'(res_valid), 32'd0);
        tick();
        check("lat_e2_valid", 32'(res_valid), 32'd1);
        check("lat_y",        32'(res_y), 32'h0000);
        check("lat_flags",    {28'd0, res_carry, res_zero, res_neg, res_dz}, 32'b1100);
        tick();
        check("lat_clear", 32'(res_valid), 32'd0);

        // Backpressure fill: five accepted, FIFO full
        res_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            exp_y[i]  = 16'(16'h1000 + i + 16'h0100 * i);
            cmd_valid = 1'b1;
            cmd_a     = 16'(16'h1000 + i);
            cmd_b     = 16'(16'h0100 * i);
            cmd_op    = 4'b0000;
            cmd_acc   = 1'b0;
            if (cmd_ready) accepted++;
            tick();
        end
        cmd_valid = 1'b0;
        check("bp_accepted",  32'(accepted), 32'd5);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_level",     32'(fifo_level), 32'd4);
        check("bp_first_y",   32'(res_y), 32'(exp_y[0]));

        res_ready = 1'b1;
        n         = 0;
        first_cyc = 0;
        last_cyc  = 0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            if (res_valid) begin
                check("bp_drain_y", 32'(res_y), 32'(exp_y[n]));
                if (n == 0) first_cyc = cyc;
                last_cyc = cyc;
                n++;
            end
            tick();
        end
        check("bp_drain_count", 32'(n), 32'd5);
        check("bp_drain_span",  32'(last_cyc - first_cyc), 32'd8);
        check("bp_drain_level", 32'(fifo_level), 32'd0);

        // Divide by zero flag, then an ordinary divide
        issue(16'h1234, 16'h0000, 4'b1011, 1'b0);
        wait_res("dz_timeout");
        check("dz_y",     32'(res_y), 32'h0000);
        check("dz_flags", {29'd0, res_zero, res_dz, res_carry}, 32'b110);
        issue(16'h0010, 16'h0004, 4'b1011, 1'b0);
        wait_res("div_timeout");
        check("div_y",     32'(res_y), 32'h0004);
        check("div_flags", {29'd0, res_zero, res_dz, res_carry}, 32'b000);
        tick();

        // Hold: slot occupied, second command must stay queued
        res_ready = 1'b0;
        issue(16'h00FF, 16'h8F0F, 4'b0010, 1'b0);
        issue(16'h0001, 16'h0001, 4'b0000, 1'b0);
        wait_res("hold_timeout");
        check("hold_y",   32'(res_y), 32'h000F);
        check("hold_neg", 32'(res_neg), 32'd0);
        held_y = res_y;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!res_valid || res_y !== held_y || res_zero || res_dz
                || fifo_level !== 3'd1) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("hold_release", 32'(res_valid), 32'd0);
        tick();
        check("hold_next_y", 32'(res_y), 32'h0002);
        res_ready = 1'b1;
        tick();

        // Reset while a command is in DRIVE with more queued
        res_ready = 1'b0;
        issue(16'h8000, 16'h0001, 4'b0000, 1'b0);
        issue(16'h0002, 16'h0003, 4'b0000, 1'b0);
        issue(16'h0004, 16'h0005, 4'b0000, 1'b0);
        issue(16'h0006, 16'h0007, 4'b0000, 1'b0);
        check("rm_level_pre", 32'(fifo_level), 32'd3);
        check("rm_neg_pre",   32'(res_neg), 32'd1);
        res_ready = 1'b1;
        tick();
        check("rm_in_drive", 32'(fifo_level), 32'd2);
        rst       = 1'b1;
        res_ready = 1'b0;
        tick();
        rst       = 1'b0;
        res_ready = 1'b1;
        check("rm_valid",     32'(res_valid), 32'd0);
        check("rm_level",     32'(fifo_level), 32'd0);
        check("rm_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rm_alu",       {alu_a, alu_b[11:0], alu_s}, 32'd0);
        check("rm_res",       {11'd0, res_y, res_carry, res_zero, res_neg, res_dz}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check("rm_no_result", 32'(seen), 32'd0);

        // Accumulator as operand A
        issue(16'h0005, 16'h0003, 4'b0000, 1'b0);
        wait_res("acc1_timeout");
        check("acc1_y", 32'(res_y), 32'h0008);
        issue(16'h0100, 16'h0002, 4'b0001, 1'b1);
        wait_res("acc2_timeout");
`ifdef ALU_ACC_EN
        check("acc2_y", 32'(res_y), 32'h0006);
`else
        check("acc2_y", 32'(res_y), 32'h00FE);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
